mem_data_responder: RTL and testbench

//  Data-memory responder: the target end of the MEM-stage load/store interface.

---
 rtl/mem_data_responder.sv | 173 +++++++++++++++++
 tb/tb_mem_data_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_data_responder.sv
// MEM-stage data-memory responder: word RAM with wait states, load-valid pulse and address check.
// Optional MEM_PERF_COUNT_EN adds saturating Read_Count / Write_Count ports.
`timescale 1ns/1ps
module mem_data_responder #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  input  logic [3:0]  Byte_En_MEM,
  output logic [31:0] Read_Data_MEM,
  output logic        Read_Valid_MEM,
  output logic        Stall_MEM,
`ifdef MEM_PERF_COUNT_EN
  output logic [15:0] Read_Count,
  output logic [15:0] Write_Count,
`endif
  output logic        Addr_Error_MEM
);

  localparam int unsigned Words = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  aerr_q, aerr_d;
  logic                  stall;
  logic                  go_resp;
  logic [ADDR_WIDTH-1:0] acc_idx;
  logic                  acc_we, acc_err;

  logic [31:0] mem_q [Words];

  logic                  req;
  logic                  in_err;
  logic [ADDR_WIDTH-1:0] in_idx;

  assign req    = MemRead_MEM | MemWrite_MEM;
  assign in_err = (ALU_Result_MEM[1:0] != 2'b00) ||
                  ((ALU_Result_MEM >> (ADDR_WIDTH + 2)) != 32'd0);
  assign in_idx = ALU_Result_MEM[ADDR_WIDTH+1:2];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    aerr_d   = 1'b0;
    stall    = 1'b0;
    go_resp  = 1'b0;
    acc_idx  = idx_q;
    acc_we   = we_q;
    acc_err  = err_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          stall   = 1'b1;
          idx_d   = in_idx;
          wdata_d = Write_Data_MEM;
          be_d    = Byte_En_MEM;
          we_d    = MemWrite_MEM;
          err_d   = in_err;
          acc_idx = in_idx;
          acc_we  = MemWrite_MEM;
          acc_err = in_err;
          if (in_err || (WAIT_STATES == 0)) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Load data is sampled on the edge entering RESP; any bad address clears it.
    if (go_resp) begin
      rvalid_d = !acc_we;
      aerr_d   = acc_err;
      if (acc_err) begin
        rdata_d = 32'd0;
      end else if (!acc_we) begin
        rdata_d = mem_q[acc_idx];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      idx_q    <= '0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
      rvalid_q <= 1'b0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      aerr_q   <= aerr_d;
    end
  end

  // RAM is not reset; the Reset_n gate aborts a store whose commit edge sees reset.
  always_ff @(posedge Clk) begin
    if (Reset_n && (state_q == StResp) && we_q && !err_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

`ifdef MEM_PERF_COUNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else if ((state_q == StResp) && !err_q) begin
      if (we_q && (wr_cnt_q != 16'hFFFF)) wr_cnt_q <= wr_cnt_q + 16'd1;
      if (!we_q && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign Read_Count  = rd_cnt_q;
  assign Write_Count = wr_cnt_q;
`endif

  assign Stall_MEM      = stall;
  assign Read_Data_MEM  = rdata_q;
  assign Read_Valid_MEM = rvalid_q;
  assign Addr_Error_MEM = aerr_q;

endmodule

// File: tb/tb_mem_data_responder.sv
// Bench for mem_data_responder: directed vector table, hand sequences, random vs. memory model.
`timescale 1ns/1ps
module tb_mem_data_responder;

  localparam int unsigned WS = 1;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        MemRead_MEM = 1'b0;
  logic        MemWrite_MEM = 1'b0;
  logic [31:0] ALU_Result_MEM = 32'd0;
  logic [31:0] Write_Data_MEM = 32'd0;
  logic [3:0]  Byte_En_MEM = 4'd0;
  logic [31:0] Read_Data_MEM;
  logic        Read_Valid_MEM;
  logic        Stall_MEM;
  logic        Addr_Error_MEM;
`ifdef MEM_PERF_COUNT_EN
  logic [15:0] Read_Count, Write_Count;
`endif

  mem_data_responder #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
    .Clk            (Clk),
    .Reset_n        (Reset_n),
    .MemRead_MEM    (MemRead_MEM),
    .MemWrite_MEM   (MemWrite_MEM),
    .ALU_Result_MEM (ALU_Result_MEM),
    .Write_Data_MEM (Write_Data_MEM),
    .Byte_En_MEM    (Byte_En_MEM),
    .Read_Data_MEM  (Read_Data_MEM),
    .Read_Valid_MEM (Read_Valid_MEM),
    .Stall_MEM      (Stall_MEM),
`ifdef MEM_PERF_COUNT_EN
    .Read_Count     (Read_Count),
    .Write_Count    (Write_Count),
`endif
    .Addr_Error_MEM (Addr_Error_MEM)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t        tbl [15];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] held;
  int          checks = 0;
  int          failures = 0;
  int          exp_rc = 0;
  int          exp_wc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] w;
    w = ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'd0;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[a >> 2] = w;
  endtask

  // One full access: stall count, RESP outputs, then pulses gone once the request is dropped.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic [31:0] exp_rd, input bit exp_err);
    int stalls;
    bit done;
    @(posedge Clk); #1;
    MemRead_MEM = rd; MemWrite_MEM = wr; ALU_Result_MEM = a; Write_Data_MEM = d;
    Byte_En_MEM = be;
    stalls = 0;
    done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (Stall_MEM) stalls++;
      else done = 1;
    end
    chk("resp_reached", 32'(done), 32'd1);
    chk("stall_cycles", 32'(stalls), exp_err ? 32'd1 : 32'(WS + 1));
    chk("resp_valid", 32'(Read_Valid_MEM), 32'(!wr));
    chk("resp_err", 32'(Addr_Error_MEM), 32'(exp_err));
    chk("resp_rdata", Read_Data_MEM, exp_rd);
    @(posedge Clk); #1;
    MemRead_MEM = 0; MemWrite_MEM = 0;
    @(negedge Clk);
    chk("post_stall", 32'(Stall_MEM), 32'd0);
    chk("post_valid", 32'(Read_Valid_MEM), 32'd0);
    chk("post_err", 32'(Addr_Error_MEM), 32'd0);
  endtask

  logic [31:0] a, wd, er;
  logic [3:0]  be;
  bit          rd, wr, err;
  int          k;

  initial begin
    tbl[0]  = '{0, 1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        0};
    tbl[1]  = '{1, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 0};
    tbl[2]  = '{0, 1, 32'h10,   32'h000000AA, 4'h1, 32'hDEADBEEF, 0};
    tbl[3]  = '{1, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 0};
    tbl[4]  = '{1, 0, 32'h13,   32'h0,        4'h0, 32'h0,        1};
    tbl[5]  = '{1, 0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 0};
    tbl[6]  = '{1, 1, 32'h24,   32'h77,       4'hF, 32'hDEADBEAA, 0};
    tbl[7]  = '{1, 0, 32'h24,   32'h0,        4'h0, 32'h77,       0};
    tbl[8]  = '{1, 0, 32'h1000, 32'h0,        4'h0, 32'h0,        1};
    tbl[9]  = '{0, 1, 32'h20,   32'h5,        4'hF, 32'h0,        0};
    tbl[10] = '{1, 0, 32'h20,   32'h0,        4'h0, 32'h5,        0};
    tbl[11] = '{0, 1, 32'hFFC,  32'hCAFEF00D, 4'hF, 32'h5,        0};
    tbl[12] = '{1, 0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEF00D, 0};
    tbl[13] = '{0, 1, 32'h2,    32'h12345678, 4'hF, 32'h0,        1};
    tbl[14] = '{1, 0, 32'h20,   32'h0,        4'h0, 32'h5,        0};

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_stall", 32'(Stall_MEM), 32'd0);
    chk("rst_valid", 32'(Read_Valid_MEM), 32'd0);
    chk("rst_rdata", Read_Data_MEM, 32'd0);
    chk("rst_err", 32'(Addr_Error_MEM), 32'd0);
    Reset_n = 1;
    held = 32'd0;

    for (int i = 0; i < 15; i++) begin
      access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].exp_rdata,
             tbl[i].exp_err);
      if (tbl[i].wr && !tbl[i].exp_err) model_store(tbl[i].addr, tbl[i].wdata, tbl[i].be);
      held = tbl[i].exp_rdata;
    end

    // Request dropped mid-WAIT: latched load still completes.
    @(posedge Clk); #1;
    MemRead_MEM = 1; ALU_Result_MEM = 32'h24;
    @(negedge Clk);
    chk("drop_stall0", 32'(Stall_MEM), 32'd1);
    @(posedge Clk); #1;
    MemRead_MEM = 0;
    @(negedge Clk);
    chk("drop_stall1", 32'(Stall_MEM), 32'd1);
    @(negedge Clk);
    chk("drop_resp_stall", 32'(Stall_MEM), 32'd0);
    chk("drop_resp_valid", 32'(Read_Valid_MEM), 32'd1);
    chk("drop_resp_rdata", Read_Data_MEM, 32'h77);
    held = 32'h77;

`ifdef MEM_PERF_COUNT_EN
    chk("perf_wr", 32'(Write_Count), 32'd5);
    chk("perf_rd", 32'(Read_Count), 32'd8);
`endif

    // Reset during WAIT aborts the pending store.
    @(posedge Clk); #1;
    MemWrite_MEM = 1; ALU_Result_MEM = 32'h20; Write_Data_MEM = 32'h11111111; Byte_En_MEM = 4'hF;
    @(negedge Clk);
    chk("abort_stall0", 32'(Stall_MEM), 32'd1);
    @(posedge Clk); #1;
    Reset_n = 0;
    MemWrite_MEM = 0;
    #1;
    chk("abort_stall", 32'(Stall_MEM), 32'd0);
    chk("abort_valid", 32'(Read_Valid_MEM), 32'd0);
    chk("abort_rdata", Read_Data_MEM, 32'd0);
    @(posedge Clk); #1;
    Reset_n = 1;
    access(1, 0, 32'h20, 32'h0, 4'h0, 32'h5, 0);
    held = 32'h5;
    exp_rc = 1;
    exp_wc = 0;

    for (int i = 0; i < 80; i++) begin
      k  = $urandom_range(0, 9);
      wd = $urandom;
      be = 4'($urandom_range(0, 15));
      if (k == 0) a = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else if (k == 1) a = ($urandom | 32'h1000) & 32'hFFFF_FFFC;
      else a = 32'($urandom_range(0, 63)) << 2;
      err = (a[1:0] != 2'b00) || (a >= 32'h1000);
      rd  = 1'($urandom_range(0, 1));
      wr  = !rd;
      if (wr && $urandom_range(0, 3) == 0) rd = 1;
      if (!err && !wr && !ref_mem.exists(a >> 2)) wr = 1;
      if (!err && wr && !ref_mem.exists(a >> 2)) be = 4'hF;
      if (err) begin
        er = 32'd0;
        held = 32'd0;
      end else if (!wr) begin
        er = ref_mem[a >> 2];
        held = er;
        exp_rc++;
      end else begin
        er = held;
        exp_wc++;
      end
      access(rd, wr, a, wd, be, er, err);
      if (wr && !err) model_store(a, wd, be);
    end

`ifdef MEM_PERF_COUNT_EN
    chk("perf_rand_wr", 32'(Write_Count), 32'(exp_wc));
    chk("perf_rand_rd", 32'(Read_Count), 32'(exp_rc));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
